captura_jogada: RTL and testbench
=================================

Name: captura_jogada

Overview:
Input-capture controller for the Sudoku move-entry path, placed directly upstream of the input display stage. It debounces the confirm/cancel keys and decodes the 9 one-hot value switches. It steps the player through row -> column -> editability check -> value, holding regLinha/regColuna/regValor and estadoJogo for the display. A finished move goes to board memory through a req/ack write handshake.

Parameters:
DEBOUNCE_CICLOS, 500000, cycles a key must be stable before a press is accepted (10 ms at 50 MHz).
ERRO_CICLOS, 25000000, cycles spent in ERRO before returning to LINHA (0.5 s at 50 MHz).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
switch  in  9  value switches; switch[k] high selects digit k+1
btn_confirma_n  in  1  confirm key, active-low, asynchronous to clk
btn_cancela_n  in  1  cancel key, active-low, asynchronous to clk
celula_fixa  in  1  board memory: addressed cell is a given (not editable); valid 1 cycle after addr_celula is stable
ack_escrita  in  1  board memory write acknowledge, 1-cycle pulse
regLinha  out  4  selected row 1..9, 0 = none
regColuna  out  4  selected column 1..9, 0 = none
regValor  out  4  selected value 1..9, 0 = none
estadoJogo  out  3  current FSM state code
addr_celula  out  7  (regLinha-1)*9 + (regColuna-1); 0 when either register is 0
req_escrita  out  1  write request, level
erro  out  1  high while in ERRO; also a 1-cycle pulse on an invalid confirm

Behaviour:
- Reset (async, any time, including mid-handshake):
  - regLinha = regColuna = regValor = 0; estadoJogo = LINHA; req_escrita = 0; erro = 0.
  - Debouncers and all counters clear.
- Key path:
  - 2-flop synchroniser, then a stability counter.
  - Press is accepted after DEBOUNCE_CICLOS consecutive low samples.
  - Output is a single 1-cycle pulse per press; no repeat while held. A release must also be stable before the next press counts.
- Switch decode: exactly one bit high -> value 1..9, otherwise invalid (0). Decode is combinational on the current switch value.
- State codes: LINHA 3'b000, COLUNA 3'b001, VERIFICA 3'b010, VALOR 3'b011, ESCREVE 3'b100, ERRO 3'b101.
- LINHA, confirm pulse:
  - valid decode: regLinha <= decode; go to COLUNA.
  - invalid decode: 1-cycle erro pulse; stay in LINHA.
- COLUNA, confirm pulse: same rule, loading regColuna; valid goes to VERIFICA.
- VERIFICA: 2 cycles. Cycle 1 lets addr_celula settle. Cycle 2 samples celula_fixa:
  - 1 -> ERRO.
  - 0 -> VALOR.
- VALOR, confirm pulse:
  - valid decode: regValor <= decode; go to ESCREVE.
  - invalid decode: erro pulse; stay in VALOR.
- ESCREVE:
  - req_escrita = 1 from the entry cycle until the cycle ack_escrita is sampled high.
  - Next cycle: req_escrita = 0, all registers 0, state LINHA.
  - No timeout. Confirm and cancel are ignored here.
- ERRO:
  - erro = 1; counter runs ERRO_CICLOS cycles, then registers clear and state goes to LINHA.
  - Cancel exits early.
- Cancel pulse in LINHA, COLUNA, VERIFICA, VALOR or ERRO: registers clear to 0; state goes to LINHA the next cycle.
- Confirm and cancel pulses in the same cycle: cancel wins.
- ack_escrita outside ESCREVE: ignored.
- Outputs are registered, except addr_celula, which is combinational from the registers (multiply by 9 implemented as shift-add, 7-bit result, max 80).
- Unused state codes 110/111 go to LINHA with registers cleared.

Decomposition:
- Package: state codes, ADDR_W = 7, N_CELULAS = 81.
- One sub-module, debounce_botao (synchroniser + stability counter + press pulse, parameter DEBOUNCE_CICLOS), instantiated twice.
- Switch decode and FSM live in captura_jogada.

Test Plan:
All tests use DEBOUNCE_CICLOS=4 and ERRO_CICLOS=8.
1. Happy path:
   - switch=9'b000000100 + confirm -> regLinha=3, estadoJogo=001.
   - switch=9'b000010000 + confirm -> regColuna=5; VERIFICA with addr_celula=22.
   - celula_fixa=0 -> VALOR.
   - switch=9'b100000000 + confirm -> regValor=9; req_escrita=1 until ack; then all regs 0, state 000.
2. Invalid switches: switch=0 or 9'b000000011 + confirm in LINHA -> erro pulses 1 cycle, state stays 000, regLinha stays 0.
3. Fixed cell: row 1, col 1 (addr_celula=0), celula_fixa=1 -> state 101, erro=1 for 8 cycles, then state 000 and regs 0.
4. Key behaviour:
   - Bounce: confirm glitching low for 2 cycles -> no state change.
   - Held: confirm held 100 cycles -> exactly one advance.
   - Both keys: confirm and cancel pressed together in COLUNA -> state 000, regs 0.
5. Write handshake: in ESCREVE, ack delayed 20 cycles, cancel pressed meanwhile -> req_escrita stays 1, state stays 100 until ack, then 000.
6. Reset mid-handshake: assert reset while req_escrita=1, asynchronously between clock edges -> all outputs 0 and state 000 immediately, with no clock edge needed.

Source files
------------

// File: rtl/captura_jogada_pkg.sv
// Shared types and helpers for the Sudoku move-capture path: state codes,
// switch decode and cell-address arithmetic.
package captura_jogada_pkg;

    typedef enum logic [2:0] {
        LINHA    = 3'b000,
        COLUNA   = 3'b001,
        VERIFICA = 3'b010,
        VALOR    = 3'b011,
        ESCREVE  = 3'b100,
        ERRO     = 3'b101
    } estado_t;

    localparam int ADDR_W    = 7;
    localparam int N_CELULAS = 81;
    localparam int N_DIGITOS = 9;

    // One-hot switch word to digit 1..9; anything not exactly one-hot gives 0.
    function automatic logic [3:0] decodifica(input logic [N_DIGITOS-1:0] sw);
        logic [3:0] val;
        int         n;
        val = 4'd0;
        n   = 0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (sw[k]) begin
                n++;
                val = 4'(k + 1);
            end
        end
        return (n == 1) ? val : 4'd0;
    endfunction

    // (linha-1)*9 + (coluna-1), with the x9 done as x8 + x1.
    function automatic logic [ADDR_W-1:0] calc_endereco(input logic [3:0] linha,
                                                        input logic [3:0] coluna);
        logic [ADDR_W-1:0] l;
        logic [ADDR_W-1:0] c;
        if (linha == 4'd0 || coluna == 4'd0) return '0;
        l = ADDR_W'(linha - 4'd1);
        c = ADDR_W'(coluna - 4'd1);
        return (l << 3) + l + c;
    endfunction

endpackage

// File: rtl/captura_jogada_if.sv
// Board-memory port of the capture controller: cell address, given-cell flag
// and the req/ack write handshake.
interface captura_jogada_if;
    import captura_jogada_pkg::*;

    logic [ADDR_W-1:0] addr_celula;
    logic              celula_fixa;
    logic              req_escrita;
    logic              ack_escrita;

    modport master (
        output addr_celula,
        output req_escrita,
        input  celula_fixa,
        input  ack_escrita
    );

    modport slave (
        input  addr_celula,
        input  req_escrita,
        output celula_fixa,
        output ack_escrita
    );

endinterface

// File: rtl/captura_jogada_debounce_botao.sv
// Active-low key conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse per accepted press.
module debounce_botao #(
    parameter int DEBOUNCE_CICLOS = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);

    logic             sync1;
    logic             sync2;
    logic             estavel;
    logic [CNT_W-1:0] cnt;

    // estavel is the accepted key level; it only flips after DEBOUNCE_CICLOS
    // consecutive samples disagree with it, in both directions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            estavel <= 1'b1;
            cnt     <= '0;
            pulso   <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            pulso <= 1'b0;
            if (sync2 == estavel) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
                estavel <= sync2;
                cnt     <= '0;
                pulso   <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/captura_jogada.sv
// Move-entry controller: row -> column -> editability check -> value -> write,
// with error hold-off and cancel from any non-write state.
module captura_jogada
    import captura_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 500000,
    parameter int ERRO_CICLOS     = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_DIGITOS-1:0] switch,
    input  logic                 btn_confirma_n,
    input  logic                 btn_cancela_n,
    captura_jogada_if.master     mem,
    output logic [3:0]           regLinha,
    output logic [3:0]           regColuna,
    output logic [3:0]           regValor,
    output logic [2:0]           estadoJogo,
    output logic                 erro
);

    localparam int CNT_ERRO_W = $clog2(ERRO_CICLOS + 1);

    estado_t               estado;
    estado_t               estado_d;
    logic [3:0]            linha_d;
    logic [3:0]            coluna_d;
    logic [3:0]            valor_d;
    logic                  erro_d;
    logic                  fase_verif;
    logic                  fase_verif_d;
    logic [CNT_ERRO_W-1:0] cnt_erro;
    logic [CNT_ERRO_W-1:0] cnt_erro_d;
    logic                  limpa;
    logic                  req;
    logic                  confirma;
    logic                  cancela;
    logic [3:0]            digito;

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_confirma (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_confirma_n),
        .pulso (confirma)
    );

    debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_cancela (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_cancela_n),
        .pulso (cancela)
    );

    assign digito          = decodifica(switch);
    assign estadoJogo      = estado;
    assign mem.req_escrita = req;
    assign mem.addr_celula = calc_endereco(regLinha, regColuna);

    always_comb begin
        estado_d     = estado;
        linha_d      = regLinha;
        coluna_d     = regColuna;
        valor_d      = regValor;
        erro_d       = 1'b0;
        fase_verif_d = 1'b0;
        cnt_erro_d   = '0;
        limpa        = 1'b0;

        case (estado)
            LINHA: begin
                if (cancela) begin
                    limpa = 1'b1;
                end else if (confirma) begin
                    if (digito != 4'd0) begin
                        linha_d  = digito;
                        estado_d = COLUNA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            COLUNA: begin
                if (cancela) begin
                    limpa = 1'b1;
                end else if (confirma) begin
                    if (digito != 4'd0) begin
                        coluna_d = digito;
                        estado_d = VERIFICA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            // First cycle only lets the address reach memory; second samples it.
            VERIFICA: begin
                if (cancela) begin
                    limpa = 1'b1;
                end else if (!fase_verif) begin
                    fase_verif_d = 1'b1;
                end else begin
                    estado_d = mem.celula_fixa ? ERRO : VALOR;
                end
            end
            VALOR: begin
                if (cancela) begin
                    limpa = 1'b1;
                end else if (confirma) begin
                    if (digito != 4'd0) begin
                        valor_d  = digito;
                        estado_d = ESCREVE;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            // Keys are deliberately ignored: the write must complete once started.
            ESCREVE: begin
                if (mem.ack_escrita) limpa = 1'b1;
            end
            ERRO: begin
                if (cancela || cnt_erro == CNT_ERRO_W'(ERRO_CICLOS - 1)) begin
                    limpa = 1'b1;
                end else begin
                    cnt_erro_d = cnt_erro + CNT_ERRO_W'(1);
                end
            end
            default: begin
                limpa = 1'b1;
            end
        endcase

        if (limpa) begin
            estado_d = LINHA;
            linha_d  = 4'd0;
            coluna_d = 4'd0;
            valor_d  = 4'd0;
        end

        if (estado_d == ERRO) erro_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= LINHA;
            regLinha   <= 4'd0;
            regColuna  <= 4'd0;
            regValor   <= 4'd0;
            erro       <= 1'b0;
            req        <= 1'b0;
            fase_verif <= 1'b0;
            cnt_erro   <= '0;
        end else begin
            estado     <= estado_d;
            regLinha   <= linha_d;
            regColuna  <= coluna_d;
            regValor   <= valor_d;
            erro       <= erro_d;
            req        <= (estado_d == ESCREVE);
            fase_verif <= fase_verif_d;
            cnt_erro   <= cnt_erro_d;
        end
    end

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada with a scoreboard of expected values and
// immediate-assertion comparisons.
module tb_captura_jogada;
    import captura_jogada_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] switch;
    logic       btn_confirma_n;
    logic       btn_cancela_n;
    logic [3:0] regLinha;
    logic [3:0] regColuna;
    logic [3:0] regValor;
    logic [2:0] estadoJogo;
    logic       erro;

    captura_jogada_if mem_if();

    captura_jogada #(.DEBOUNCE_CICLOS(4), .ERRO_CICLOS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .switch         (switch),
        .btn_confirma_n (btn_confirma_n),
        .btn_cancela_n  (btn_cancela_n),
        .mem            (mem_if),
        .regLinha       (regLinha),
        .regColuna      (regColuna),
        .regValor       (regValor),
        .estadoJogo     (estadoJogo),
        .erro           (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic esp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic confere(input string tag, input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s no expectation queued, observed=%0d", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val && tag == e.tag)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (queued tag %s)", tag, obs, e.val, e.tag);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press keys for 'hold' cycles, release, and let the release settle.
    task automatic aperta(input bit conf, input bit canc, input int hold, output int n_erro);
        n_erro = 0;
        btn_confirma_n = ~conf;
        btn_cancela_n  = ~canc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (erro === 1'b1) n_erro++;
        end
        btn_confirma_n = 1'b1;
        btn_cancela_n  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (erro === 1'b1) n_erro++;
        end
    endtask

    task automatic espera_estado(input logic [2:0] code, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (estadoJogo === code) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic regs_zero(input string pre);
        esp({pre, "_lin"}, 0); confere({pre, "_lin"}, 32'(regLinha));
        esp({pre, "_col"}, 0); confere({pre, "_col"}, 32'(regColuna));
        esp({pre, "_val"}, 0); confere({pre, "_val"}, 32'(regValor));
    endtask

    initial begin
        int n_erro;
        bit ok;

        reset = 1'b1;
        switch = 9'd0;
        btn_confirma_n = 1'b1;
        btn_cancela_n  = 1'b1;
        mem_if.celula_fixa = 1'b0;
        mem_if.ack_escrita = 1'b0;
        ciclos(2);
        esp("rst_estado", 0); confere("rst_estado", 32'(estadoJogo));
        esp("rst_req", 0);    confere("rst_req", 32'(mem_if.req_escrita));
        esp("rst_erro", 0);   confere("rst_erro", 32'(erro));
        esp("rst_addr", 0);   confere("rst_addr", 32'(mem_if.addr_celula));
        regs_zero("rst");
        reset = 1'b0;
        ciclos(3);

        // Happy path: row 3, column 5, editable cell, value 9
        switch = 9'b000000100;
        esp("hp_lin_estado", 1); esp("hp_lin_reg", 3); esp("hp_lin_erro", 0);
        aperta(1, 0, 10, n_erro);
        confere("hp_lin_estado", 32'(estadoJogo));
        confere("hp_lin_reg", 32'(regLinha));
        confere("hp_lin_erro", 32'(n_erro));

        switch = 9'b000010000;
        esp("hp_verif", 1); esp("hp_addr", 22); esp("hp_valor", 1); esp("hp_col_reg", 5);
        btn_confirma_n = 1'b0;
        espera_estado(3'b010, 20, ok);
        confere("hp_verif", 32'(ok));
        confere("hp_addr", 32'(mem_if.addr_celula));
        espera_estado(3'b011, 5, ok);
        confere("hp_valor", 32'(ok));
        btn_confirma_n = 1'b1;
        ciclos(12);
        confere("hp_col_reg", 32'(regColuna));

        switch = 9'b100000000;
        esp("hp_escreve", 1); esp("hp_req", 1); esp("hp_val_reg", 9);
        btn_confirma_n = 1'b0;
        espera_estado(3'b100, 20, ok);
        confere("hp_escreve", 32'(ok));
        confere("hp_req", 32'(mem_if.req_escrita));
        confere("hp_val_reg", 32'(regValor));
        btn_confirma_n = 1'b1;
        ciclos(12);
        esp("hp_req_hold", 1); confere("hp_req_hold", 32'(mem_if.req_escrita));
        mem_if.ack_escrita = 1'b1;
        @(negedge clk);
        mem_if.ack_escrita = 1'b0;
        esp("hp_fim_req", 0);    confere("hp_fim_req", 32'(mem_if.req_escrita));
        esp("hp_fim_estado", 0); confere("hp_fim_estado", 32'(estadoJogo));
        regs_zero("hp_fim");

        // Invalid switch words in LINHA
        switch = 9'd0;
        esp("inv0_erro", 1); esp("inv0_estado", 0); esp("inv0_lin", 0);
        aperta(1, 0, 10, n_erro);
        confere("inv0_erro", 32'(n_erro));
        confere("inv0_estado", 32'(estadoJogo));
        confere("inv0_lin", 32'(regLinha));
        switch = 9'b000000011;
        esp("inv2_erro", 1); esp("inv2_estado", 0); esp("inv2_lin", 0);
        aperta(1, 0, 10, n_erro);
        confere("inv2_erro", 32'(n_erro));
        confere("inv2_estado", 32'(estadoJogo));
        confere("inv2_lin", 32'(regLinha));

        // ack outside ESCREVE has no effect
        mem_if.ack_escrita = 1'b1;
        @(negedge clk);
        mem_if.ack_escrita = 1'b0;
        esp("ack_fora", 0); confere("ack_fora", 32'(estadoJogo));

        // Fixed cell at row 1, column 1
        switch = 9'b000000001;
        aperta(1, 0, 10, n_erro);
        mem_if.celula_fixa = 1'b1;
        esp("fixa_erro_estado", 1); esp("fixa_addr", 0); esp("fixa_ciclos", 8);
        esp("fixa_volta", 0);
        btn_confirma_n = 1'b0;
        espera_estado(3'b101, 20, ok);
        confere("fixa_erro_estado", 32'(ok));
        confere("fixa_addr", 32'(mem_if.addr_celula));
        n_erro = 0;
        while (erro === 1'b1 && n_erro < 40) begin
            n_erro++;
            @(negedge clk);
        end
        confere("fixa_ciclos", 32'(n_erro));
        confere("fixa_volta", 32'(estadoJogo));
        regs_zero("fixa");
        btn_confirma_n = 1'b1;
        ciclos(12);
        mem_if.celula_fixa = 1'b0;

        // Bounce: 2-cycle glitch is not a press
        switch = 9'b000000100;
        btn_confirma_n = 1'b0;
        ciclos(2);
        btn_confirma_n = 1'b1;
        ciclos(12);
        esp("bounce_estado", 0); confere("bounce_estado", 32'(estadoJogo));
        esp("bounce_lin", 0);    confere("bounce_lin", 32'(regLinha));

        // Held key: exactly one advance
        esp("held_estado", 1); esp("held_lin", 3);
        aperta(1, 0, 100, n_erro);
        confere("held_estado", 32'(estadoJogo));
        confere("held_lin", 32'(regLinha));

        // Both keys together in COLUNA: cancel wins
        esp("ambos_estado", 0);
        aperta(1, 1, 10, n_erro);
        confere("ambos_estado", 32'(estadoJogo));
        regs_zero("ambos");

        // Write handshake with a late ack and a cancel attempt meanwhile
        switch = 9'b000000010;
        aperta(1, 0, 10, n_erro);
        switch = 9'b000000100;
        esp("hs_valor", 3); esp("hs_addr", 11);
        aperta(1, 0, 10, n_erro);
        confere("hs_valor", 32'(estadoJogo));
        confere("hs_addr", 32'(mem_if.addr_celula));
        switch = 9'b000000010;
        esp("hs_escreve", 4); esp("hs_val_reg", 2);
        aperta(1, 0, 10, n_erro);
        confere("hs_escreve", 32'(estadoJogo));
        confere("hs_val_reg", 32'(regValor));
        esp("hs_canc_estado", 4); esp("hs_canc_req", 1);
        aperta(0, 1, 10, n_erro);
        confere("hs_canc_estado", 32'(estadoJogo));
        confere("hs_canc_req", 32'(mem_if.req_escrita));
        mem_if.ack_escrita = 1'b1;
        @(negedge clk);
        mem_if.ack_escrita = 1'b0;
        esp("hs_fim_estado", 0); confere("hs_fim_estado", 32'(estadoJogo));
        esp("hs_fim_req", 0);    confere("hs_fim_req", 32'(mem_if.req_escrita));

        // Corner cell 9,9 then asynchronous reset while the request is up
        switch = 9'b100000000;
        aperta(1, 0, 10, n_erro);
        esp("canto_addr", 80);
        aperta(1, 0, 10, n_erro);
        confere("canto_addr", 32'(mem_if.addr_celula));
        switch = 9'b000000001;
        aperta(1, 0, 10, n_erro);
        esp("ar_req_antes", 1); confere("ar_req_antes", 32'(mem_if.req_escrita));
        #2 reset = 1'b1;
        #1;
        esp("ar_estado", 0); confere("ar_estado", 32'(estadoJogo));
        esp("ar_req", 0);    confere("ar_req", 32'(mem_if.req_escrita));
        esp("ar_erro", 0);   confere("ar_erro", 32'(erro));
        regs_zero("ar");
        @(negedge clk);
        reset = 1'b0;
        ciclos(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
